// File: rtl/sm4_key_exp_ctrl_pkg.sv
// Shared SM4 key-expansion constants: round count, FK words, controller state encoding
// and the on-chip CK(i) generator.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  localparam logic [31:0] FK0 = 32'ha3b1bac6;
  localparam logic [31:0] FK1 = 32'h56aa3350;
  localparam logic [31:0] FK2 = 32'h677d9197;
  localparam logic [31:0] FK3 = 32'hb27022dc;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Each CK byte is ((4*i + j) * 7) mod 256, with byte j=0 at [31:24].
  function automatic logic [31:0] ck_calc(input logic [4:0] i);
    logic [7:0] idx;
    ck_calc = '0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, i, 2'b00} + 8'(j);
      ck_calc[31-8*j -: 8] = 8'(idx * 8'd7);
    end
  endfunction

endpackage

// File: rtl/sm4_key_exp_ctrl_if.sv
// Host key-load and cipher-core read-port bundle for the SM4 key-expansion controller.
// SM4_RK_STREAM_EN adds the per-round rk stream outputs.
interface sm4_key_exp_ctrl_if;

  logic         key_start_in;
  logic [127:0] key_in;
  logic         key_busy_out;
  logic         key_ready_out;
  logic         rk_rd_en_in;
  logic [4:0]   rk_rd_addr_in;
  logic         rk_dec_order_in;
  logic [31:0]  rk_out;
  logic         rk_valid_out;
`ifdef SM4_RK_STREAM_EN
  logic         rk_stream_valid_out;
  logic [4:0]   rk_stream_idx_out;
  logic [31:0]  rk_stream_out;

  modport master (
    output key_start_in, key_in, rk_rd_en_in, rk_rd_addr_in, rk_dec_order_in,
    input  key_busy_out, key_ready_out, rk_out, rk_valid_out,
    input  rk_stream_valid_out, rk_stream_idx_out, rk_stream_out
  );
  modport slave (
    input  key_start_in, key_in, rk_rd_en_in, rk_rd_addr_in, rk_dec_order_in,
    output key_busy_out, key_ready_out, rk_out, rk_valid_out,
    output rk_stream_valid_out, rk_stream_idx_out, rk_stream_out
  );
`else
  modport master (
    output key_start_in, key_in, rk_rd_en_in, rk_rd_addr_in, rk_dec_order_in,
    input  key_busy_out, key_ready_out, rk_out, rk_valid_out
  );
  modport slave (
    input  key_start_in, key_in, rk_rd_en_in, rk_rd_addr_in, rk_dec_order_in,
    output key_busy_out, key_ready_out, rk_out, rk_valid_out
  );
`endif

endinterface

// File: rtl/sm4_key_exp_ctrl_one_round.sv
// One combinational SM4 key-expansion round: {K0..K3} -> {K1,K2,K3,K4}.
// Round 0 folds in the FK whitening so the controller can load the raw user key.
module one_round_for_key_exp
  import sm4_pkg::*;
(
  input  logic [4:0]   count_round_in,
  input  logic [127:0] data_in,
  input  logic [31:0]  ck_parameter_in,
  output logic [127:0] result_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  logic [127:0] k_cur;
  logic [31:0]  t_in;
  logic [31:0]  tau_out;
  logic [31:0]  l_out;

  assign k_cur   = (count_round_in == 5'd0) ? (data_in ^ {FK0, FK1, FK2, FK3}) : data_in;
  assign t_in    = k_cur[95:64] ^ k_cur[63:32] ^ k_cur[31:0] ^ ck_parameter_in;
  assign tau_out = {SBOX[t_in[31:24]], SBOX[t_in[23:16]], SBOX[t_in[15:8]], SBOX[t_in[7:0]]};
  // Key-schedule linear transform: B ^ (B <<< 13) ^ (B <<< 23).
  assign l_out   = tau_out ^ {tau_out[18:0], tau_out[31:19]} ^ {tau_out[8:0], tau_out[31:9]};

  assign result_out = {k_cur[95:0], k_cur[127:96] ^ l_out};

endmodule

// File: rtl/sm4_key_exp_ctrl.sv
// SM4 key-expansion controller: 32 rounds at one per clock into a 32x32 rk file, served
// through a 1-clock registered read port. SM4_RK_STREAM_EN adds a registered rk write stream.
module sm4_key_exp_ctrl
  import sm4_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  sm4_key_exp_ctrl_if.slave bus
);

  state_t        st;
  logic [4:0]    round_cnt;
  logic [127:0]  state_reg;
  logic          key_busy;
  logic          key_ready;
  logic [31:0]   ck_value;
  logic [127:0]  round_result;
  logic [31:0]   rk_file [SM4_ROUNDS];
  logic [4:0]    addr_eff;
  logic [31:0]   rk_q;
  logic          rk_valid_q;

  assign ck_value = ck_calc(round_cnt);

  one_round_for_key_exp u_one_round_key (
    .count_round_in  (round_cnt),
    .data_in         (state_reg),
    .ck_parameter_in (ck_value),
    .result_out      (round_result)
  );

  // Starts arriving during RUN are dropped; the 31->0 counter wrap is the normal exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= ST_IDLE;
      round_cnt <= '0;
      state_reg <= '0;
      key_busy  <= 1'b0;
      key_ready <= 1'b0;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (bus.key_start_in) begin
            st        <= ST_RUN;
            state_reg <= bus.key_in;
            round_cnt <= '0;
            key_ready <= 1'b0;
            key_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          state_reg <= round_result;
          round_cnt <= round_cnt + 5'd1;
          if (round_cnt == 5'd31) begin
            st        <= ST_DONE;
            key_busy  <= 1'b0;
            key_ready <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SM4_ROUNDS; i++) rk_file[i] <= '0;
    end else if (st == ST_RUN) begin
      rk_file[round_cnt] <= round_result[31:0];
    end
  end

  assign addr_eff = bus.rk_dec_order_in ? (5'd31 - bus.rk_rd_addr_in) : bus.rk_rd_addr_in;

  // rk_out only moves on a qualified read, so a not-ready read leaves it untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      rk_valid_q <= bus.rk_rd_en_in & key_ready;
      if (bus.rk_rd_en_in && key_ready) rk_q <= rk_file[addr_eff];
    end
  end

  assign bus.key_busy_out  = key_busy;
  assign bus.key_ready_out = key_ready;
  assign bus.rk_out        = rk_q;
  assign bus.rk_valid_out  = rk_valid_q;

`ifdef SM4_RK_STREAM_EN
  logic        stream_vld;
  logic [4:0]  stream_idx;
  logic [31:0] stream_dat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stream_vld <= 1'b0;
      stream_idx <= '0;
      stream_dat <= '0;
    end else begin
      stream_vld <= (st == ST_RUN);
      if (st == ST_RUN) begin
        stream_idx <= round_cnt;
        stream_dat <= round_result[31:0];
      end
    end
  end

  assign bus.rk_stream_valid_out = stream_vld;
  assign bus.rk_stream_idx_out   = stream_idx;
  assign bus.rk_stream_out       = stream_dat;
`endif

endmodule
